// File: rtl/conv2_pe_seq_if.sv
// Handshake/control bundle between the conv2 PE sequencer and its environment.
// master: the sequencer side (drives PE control, psum stream, status).
// slave:  the job issuer / PE datapath / psum consumer side.
interface conv2_pe_seq_if #(
    parameter int CNT_W = 12
);
    logic                start_i;
    logic [CNT_W-1:0]    win_num_i;
    logic                ready_o;
    logic                busy_o;
    logic                win_valid_i;
    logic                win_ack_o;
    logic [4:0]          cnt_o;
    logic signed [19:0]  pe_data_i;
    logic signed [19:0]  psum_o;
    logic                psum_ch_o;
    logic                psum_valid_o;
    logic                psum_ready_i;
    logic                done_o;
    logic                err_o;

    modport master (
        input  start_i, win_num_i, win_valid_i, pe_data_i, psum_ready_i,
        output ready_o, busy_o, win_ack_o, cnt_o, psum_o, psum_ch_o,
               psum_valid_o, done_o, err_o
    );

    modport slave (
        output start_i, win_num_i, win_valid_i, pe_data_i, psum_ready_i,
        input  ready_o, busy_o, win_ack_o, cnt_o, psum_o, psum_ch_o,
               psum_valid_o, done_o, err_o
    );
endinterface

// File: rtl/conv2_pe_seq.sv
// Two-channel convolution PE sequencer: per window, steps the PE through
// NUM_TAPS taps of channel 0 then channel 1, capturing each channel's
// accumulator result into a valid/ready psum output register.
// Optional build macro CONV2_SEQ_CHK_EN enables a sticky err_o flag raised
// when win_valid_i drops during RUN or CAP; without it err_o is tied low.
module conv2_pe_seq #(
    parameter int NUM_TAPS = 9,
    parameter int CNT_W    = 12
) (
    input logic            clk,
    input logic            rst_n,
    conv2_pe_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RUN, CAP} state_t;

    localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);

    state_t             state;
    logic               ch;
    logic [3:0]         tap;
    logic [CNT_W-1:0]   remaining;
    logic [4:0]         cnt;
    logic               win_ack;
    logic               done;
    logic signed [19:0] psum;
    logic               psum_ch;
    logic               psum_valid;
    logic               out_free;

    // A new channel may start only if its psum will have somewhere to land.
    assign out_free = !psum_valid || bus.psum_ready_i;

    assign bus.ready_o      = (state == IDLE);
    assign bus.busy_o       = (state != IDLE);
    assign bus.cnt_o        = cnt;
    assign bus.win_ack_o    = win_ack;
    assign bus.done_o       = done;
    assign bus.psum_o       = psum;
    assign bus.psum_ch_o    = psum_ch;
    assign bus.psum_valid_o = psum_valid;

    // cnt is registered alongside the state so it already shows the CAP
    // value {~ch, 0} on the cycle CAP is entered.
    // Sequencer: state, channel/tap/window counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= 1'b0;
            tap        <= '0;
            remaining  <= '0;
            cnt        <= '0;
            psum       <= '0;
            psum_ch    <= 1'b0;
            psum_valid <= 1'b0;
            win_ack    <= 1'b0;
            done       <= 1'b0;
        end else begin
            win_ack <= 1'b0;
            done    <= 1'b0;
            if (psum_valid && bus.psum_ready_i) psum_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        remaining <= bus.win_num_i;
                        ch        <= 1'b0;
                        tap       <= '0;
                        cnt       <= '0;
                        if (bus.win_num_i == '0) done  <= 1'b1;
                        else                     state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.win_valid_i && out_free) begin
                        if (NUM_TAPS == 1) begin
                            state   <= CAP;
                            cnt     <= {~ch, 4'd0};
                            win_ack <= ch;
                        end else begin
                            state <= RUN;
                            tap   <= 4'd1;
                            cnt   <= {ch, 4'd1};
                        end
                    end
                end
                RUN: begin
                    if (tap == LAST_TAP) begin
                        state   <= CAP;
                        tap     <= '0;
                        cnt     <= {~ch, 4'd0};
                        win_ack <= ch;
                    end else begin
                        tap <= tap + 4'd1;
                        cnt <= {ch, tap + 4'd1};
                    end
                end
                CAP: begin
                    psum       <= bus.pe_data_i;
                    psum_ch    <= ch;
                    psum_valid <= 1'b1;
                    tap        <= '0;
                    if (!ch) begin
                        ch    <= 1'b1;
                        state <= WAIT;
                        cnt   <= {1'b1, 4'd0};
                    end else begin
                        ch        <= 1'b0;
                        cnt       <= '0;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining > CNT_W'(1)) begin
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV2_SEQ_CHK_EN
    logic err;

    // Sticky flag for window data vanishing mid-window; a new job clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && bus.start_i) begin
            err <= 1'b0;
        end else if ((state == RUN || state == CAP) && !bus.win_valid_i) begin
            err <= 1'b1;
        end
    end

    assign bus.err_o = err;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_conv2_pe_seq.sv
// Self-checking bench for conv2_pe_seq (NUM_TAPS=9 main instance plus a
// NUM_TAPS=1 instance). Cycle n is the interval after clock edge n; outputs
// are checked 1 time unit after the edge, then that cycle's inputs are driven.
module tb_conv2_pe_seq;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [20:0] sb_q[$];

    conv2_pe_seq_if #(.CNT_W(12)) bus ();
    conv2_pe_seq_if #(.CNT_W(12)) bus1 ();

    conv2_pe_seq #(.NUM_TAPS(9), .CNT_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    conv2_pe_seq #(.NUM_TAPS(1), .CNT_W(12)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on every psum handshake of the main instance.
    always @(negedge clk) begin
        if (rst_n && bus.psum_valid_o && bus.psum_ready_i) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got psum=%0d ch=%0d required none", bus.psum_o, bus.psum_ch_o);
            end else begin
                logic [20:0] e;
                e = sb_q.pop_front();
                if ({bus.psum_ch_o, bus.psum_o} !== e) begin
                    failures++;
                    $display("FAIL sb_psum got ch=%0d psum=%0d required ch=%0d psum=%0d",
                             bus.psum_ch_o, bus.psum_o, e[20], $signed(e[19:0]));
                end
            end
        end
    end

    task automatic test_reset;
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got %0b required 1", bus.ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got %0b required 0", bus.busy_o); end
        checks++; if (bus.cnt_o !== 5'd0) begin failures++; $display("FAIL rst_cnt got %0d required 0", bus.cnt_o); end
        checks++; if (bus.psum_o !== 20'sd0) begin failures++; $display("FAIL rst_psum got %0d required 0", bus.psum_o); end
        checks++; if (bus.psum_ch_o !== 1'b0) begin failures++; $display("FAIL rst_psum_ch got %0b required 0", bus.psum_ch_o); end
        checks++; if (bus.psum_valid_o !== 1'b0) begin failures++; $display("FAIL rst_psum_valid got %0b required 0", bus.psum_valid_o); end
        checks++; if (bus.win_ack_o !== 1'b0) begin failures++; $display("FAIL rst_win_ack got %0b required 0", bus.win_ack_o); end
        checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL rst_done got %0b required 0", bus.done_o); end
        checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL rst_err got %0b required 0", bus.err_o); end
    endtask

    // Single window, full-rate: exact cycle timeline of cnt/ack/done/valid.
    task automatic test_basic(input logic signed [19:0] cap0_val);
        logic [4:0] exp_cnt;
        logic exp_ready, exp_ack, exp_done, exp_valid;
        for (int n = 0; n <= 24; n++) begin
            if (n > 0) tick();
            exp_cnt   = (n >= 1 && n <= 9)   ? 5'(n - 1) :
                        (n == 10)            ? 5'd16 :
                        (n >= 11 && n <= 19) ? 5'(16 + n - 11) : 5'd0;
            exp_ready = (n == 0) || (n >= 21);
            exp_ack   = (n == 20);
            exp_done  = (n == 21);
            exp_valid = (n == 11) || (n == 21);
            checks++; if (bus.cnt_o !== exp_cnt) begin failures++; $display("FAIL basic_cnt cyc %0d got %0d required %0d", n, bus.cnt_o, exp_cnt); end
            checks++; if (bus.ready_o !== exp_ready) begin failures++; $display("FAIL basic_ready cyc %0d got %0b required %0b", n, bus.ready_o, exp_ready); end
            checks++; if (bus.busy_o !== !exp_ready) begin failures++; $display("FAIL basic_busy cyc %0d got %0b required %0b", n, bus.busy_o, !exp_ready); end
            checks++; if (bus.win_ack_o !== exp_ack) begin failures++; $display("FAIL basic_ack cyc %0d got %0b required %0b", n, bus.win_ack_o, exp_ack); end
            checks++; if (bus.done_o !== exp_done) begin failures++; $display("FAIL basic_done cyc %0d got %0b required %0b", n, bus.done_o, exp_done); end
            checks++; if (bus.psum_valid_o !== exp_valid) begin failures++; $display("FAIL basic_valid cyc %0d got %0b required %0b", n, bus.psum_valid_o, exp_valid); end
            if (n == 11) begin
                checks++; if (bus.psum_o !== cap0_val) begin failures++; $display("FAIL basic_psum0 got %0d required %0d", bus.psum_o, cap0_val); end
            end
            bus.start_i      = (n == 0);
            bus.win_num_i    = 12'd1;
            bus.win_valid_i  = 1'b1;
            bus.psum_ready_i = 1'b1;
            bus.pe_data_i    = (n == 10) ? cap0_val : 20'($urandom);
            if (n == 10 || n == 20) sb_q.push_back({(n == 20), bus.pe_data_i});
        end
    endtask

    // Output back-pressure holds channel 1 in WAIT with psum stable.
    task automatic test_stall;
        logic [4:0] exp_cnt;
        logic exp_valid;
        logic signed [19:0] val0;
        val0 = '0;
        for (int n = 0; n <= 55; n++) begin
            if (n > 0) tick();
            exp_cnt   = (n >= 1 && n <= 9)   ? 5'(n - 1) :
                        (n >= 10 && n <= 41) ? 5'd16 :
                        (n >= 42 && n <= 49) ? 5'(16 + n - 41) : 5'd0;
            exp_valid = (n >= 11 && n <= 41) || (n == 51);
            checks++; if (bus.cnt_o !== exp_cnt) begin failures++; $display("FAIL stall_cnt cyc %0d got %0d required %0d", n, bus.cnt_o, exp_cnt); end
            checks++; if (bus.psum_valid_o !== exp_valid) begin failures++; $display("FAIL stall_valid cyc %0d got %0b required %0b", n, bus.psum_valid_o, exp_valid); end
            checks++; if (bus.win_ack_o !== (n == 50)) begin failures++; $display("FAIL stall_ack cyc %0d got %0b required %0b", n, bus.win_ack_o, (n == 50)); end
            checks++; if (bus.done_o !== (n == 51)) begin failures++; $display("FAIL stall_done cyc %0d got %0b required %0b", n, bus.done_o, (n == 51)); end
            if (n >= 11 && n <= 41) begin
                checks++; if (bus.psum_o !== val0) begin failures++; $display("FAIL stall_psum_hold cyc %0d got %0d required %0d", n, bus.psum_o, val0); end
            end
            bus.start_i      = (n == 0);
            bus.win_num_i    = 12'd1;
            bus.win_valid_i  = 1'b1;
            bus.psum_ready_i = !(n >= 11 && n <= 40);
            bus.pe_data_i    = 20'($urandom);
            if (n == 10) val0 = bus.pe_data_i;
            if (n == 10 || n == 50) sb_q.push_back({(n == 50), bus.pe_data_i});
        end
    endtask

    // win_valid low in WAIT stalls; low in RUN only affects err_o.
    task automatic test_valid_gap;
        logic [4:0] exp_cnt;
        logic exp_err;
        for (int n = 0; n <= 30; n++) begin
            if (n > 0) tick();
            exp_cnt = (n >= 7 && n <= 14)  ? 5'(n - 6) :
                      (n == 15)            ? 5'd16 :
                      (n >= 16 && n <= 24) ? 5'(n) : 5'd0;
`ifdef CONV2_SEQ_CHK_EN
            exp_err = (n >= 12);
`else
            exp_err = 1'b0;
`endif
            checks++; if (bus.cnt_o !== exp_cnt) begin failures++; $display("FAIL gap_cnt cyc %0d got %0d required %0d", n, bus.cnt_o, exp_cnt); end
            checks++; if (bus.err_o !== exp_err) begin failures++; $display("FAIL gap_err cyc %0d got %0b required %0b", n, bus.err_o, exp_err); end
            checks++; if (bus.win_ack_o !== (n == 25)) begin failures++; $display("FAIL gap_ack cyc %0d got %0b required %0b", n, bus.win_ack_o, (n == 25)); end
            checks++; if (bus.done_o !== (n == 26)) begin failures++; $display("FAIL gap_done cyc %0d got %0b required %0b", n, bus.done_o, (n == 26)); end
            bus.start_i      = (n == 0);
            bus.win_num_i    = 12'd1;
            bus.win_valid_i  = !((n >= 1 && n <= 5) || n == 11);
            bus.psum_ready_i = 1'b1;
            bus.pe_data_i    = 20'($urandom);
            if (n == 15 || n == 25) sb_q.push_back({(n == 25), bus.pe_data_i});
        end
    endtask

    // Three windows with start held during busy, then a zero-window job.
    task automatic test_multi;
        int acks, dones;
        acks = 0;
        dones = 0;
        for (int n = 0; n <= 70; n++) begin
            if (n > 0) tick();
            if (bus.win_ack_o === 1'b1) acks++;
            if (bus.done_o === 1'b1) dones++;
            checks++; if (bus.win_ack_o !== (n == 20 || n == 40 || n == 60)) begin failures++; $display("FAIL multi_ack cyc %0d got %0b", n, bus.win_ack_o); end
            checks++; if (bus.done_o !== (n == 61)) begin failures++; $display("FAIL multi_done cyc %0d got %0b required %0b", n, bus.done_o, (n == 61)); end
            if (n == 1) begin
                checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL multi_err_clear got %0b required 0", bus.err_o); end
            end
            bus.start_i      = (n == 0) || (n >= 2 && n <= 55);
            bus.win_num_i    = (n == 0) ? 12'd3 : 12'd7;
            bus.win_valid_i  = 1'b1;
            bus.psum_ready_i = 1'b1;
            bus.pe_data_i    = 20'($urandom);
            if (n > 0 && n <= 60 && (n % 10) == 0) sb_q.push_back({((n / 10) % 2 == 0), bus.pe_data_i});
        end
        checks++; if (acks != 3) begin failures++; $display("FAIL multi_ack_count got %0d required 3", acks); end
        checks++; if (dones != 1) begin failures++; $display("FAIL multi_done_count got %0d required 1", dones); end
        for (int m = 0; m <= 5; m++) begin
            if (m > 0) tick();
            checks++; if (bus.done_o !== (m == 1)) begin failures++; $display("FAIL zero_done cyc %0d got %0b required %0b", m, bus.done_o, (m == 1)); end
            checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL zero_ready cyc %0d got %0b required 1", m, bus.ready_o); end
            bus.start_i   = (m == 0);
            bus.win_num_i = 12'd0;
        end
    endtask

    // Asynchronous reset during RUN tap 4 discards the job.
    task automatic test_reset_mid;
        for (int n = 0; n <= 5; n++) begin
            if (n > 0) tick();
            bus.start_i      = (n == 0);
            bus.win_num_i    = 12'd2;
            bus.win_valid_i  = 1'b1;
            bus.psum_ready_i = 1'b1;
            bus.pe_data_i    = 20'($urandom);
        end
        checks++; if (bus.cnt_o !== 5'd4) begin failures++; $display("FAIL rmid_pre_cnt got %0d required 4", bus.cnt_o); end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            tick();
            checks++; if (bus.done_o !== 1'b0 || bus.psum_valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
                failures++;
                $display("FAIL rmid_quiet cyc %0d got done=%0b valid=%0b ready=%0b required 0 0 1", n, bus.done_o, bus.psum_valid_o, bus.ready_o);
            end
        end
        test_basic(20'($urandom));
    endtask

    // NUM_TAPS=1 instance: WAIT goes straight to CAP.
    task automatic test_single_tap;
        logic [4:0] exp_cnt;
        logic signed [19:0] d2, d4;
        d2 = '0;
        d4 = '0;
        for (int n = 0; n <= 8; n++) begin
            if (n > 0) tick();
            exp_cnt = (n == 2 || n == 3) ? 5'd16 : 5'd0;
            checks++; if (bus1.cnt_o !== exp_cnt) begin failures++; $display("FAIL tap1_cnt cyc %0d got %0d required %0d", n, bus1.cnt_o, exp_cnt); end
            checks++; if (bus1.win_ack_o !== (n == 4)) begin failures++; $display("FAIL tap1_ack cyc %0d got %0b required %0b", n, bus1.win_ack_o, (n == 4)); end
            checks++; if (bus1.done_o !== (n == 5)) begin failures++; $display("FAIL tap1_done cyc %0d got %0b required %0b", n, bus1.done_o, (n == 5)); end
            checks++; if (bus1.psum_valid_o !== (n == 3 || n == 5)) begin failures++; $display("FAIL tap1_valid cyc %0d got %0b", n, bus1.psum_valid_o); end
            if (n == 3) begin
                checks++; if ({bus1.psum_ch_o, bus1.psum_o} !== {1'b0, d2}) begin failures++; $display("FAIL tap1_psum0 got ch=%0d %0d required ch=0 %0d", bus1.psum_ch_o, bus1.psum_o, d2); end
            end
            if (n == 5) begin
                checks++; if ({bus1.psum_ch_o, bus1.psum_o} !== {1'b1, d4}) begin failures++; $display("FAIL tap1_psum1 got ch=%0d %0d required ch=1 %0d", bus1.psum_ch_o, bus1.psum_o, d4); end
            end
            bus1.start_i      = (n == 0);
            bus1.win_num_i    = 12'd1;
            bus1.win_valid_i  = 1'b1;
            bus1.psum_ready_i = 1'b1;
            bus1.pe_data_i    = 20'($urandom);
            if (n == 2) d2 = bus1.pe_data_i;
            if (n == 4) d4 = bus1.pe_data_i;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start_i = 1'b0;  bus.win_num_i = '0;  bus.win_valid_i = 1'b0;
        bus.pe_data_i = '0;  bus.psum_ready_i = 1'b0;
        bus1.start_i = 1'b0; bus1.win_num_i = '0; bus1.win_valid_i = 1'b0;
        bus1.pe_data_i = '0; bus1.psum_ready_i = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic(-20'sd524288);
        test_stall();
        test_valid_gap();
        test_multi();
        test_single_tap();
        test_reset_mid();
        tick();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
